// File: rtl/matmul_pkg.sv
// Shared widths, FSM state encoding and result payload for the matmul feeder.
package matmul_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 5;
  localparam int unsigned ROW_W  = LANE_W * LANES;
  localparam int unsigned SUM_W  = 16;
  localparam int unsigned RES_W  = SUM_W * LANES;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [RES_W-1:0] res_t;

  typedef enum logic [2:0] {
    FILL,
    START,
    SEND_W,
    SEND_I,
    WAIT,
    RESP
  } feeder_state_t;

  // Result returned to the host: multiplier sums plus status flags.
  typedef struct packed {
    res_t data;
    logic ov;
    logic timeout;
  } resp_t;

endpackage

// File: rtl/matmul_job_buf.sv
// Job word store: single write port, single registered read port, cleared on reset.
module matmul_job_buf
  import matmul_pkg::*;
#(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned AW    = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  row_t          wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output row_t          rd_data
);

  row_t mem [DEPTH];

  // Read data is zeroed when no read is requested so idle rows stay clean.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: rtl/matmul_feeder.sv
// Buffers one weight+input job from the host, streams it into the systolic
// multiplier back-to-back, then returns the captured result or a timeout.
module matmul_feeder
  import matmul_pkg::*;
#(
  parameter int unsigned N       = 5,
  parameter int unsigned T       = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [ROW_W-1:0] s_data,
  output logic             start_o,
  output logic [ROW_W-1:0] Weight_o,
  output logic [ROW_W-1:0] In_o,
  input  logic [RES_W-1:0] OUT_i,
  input  logic             VAL_i,
  input  logic             OV_i,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [RES_W-1:0] r_data,
  output logic             r_ov,
  output logic             r_timeout,
  output logic             busy_o
);

  localparam int unsigned DEPTH = N + T;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] LAST_WR = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_W  = CW'(N);
  localparam logic [CW-1:0] LAST_I  = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] seq_q, seq_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  resp_t         resp_q, resp_d;

  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [CW:0]   rd_idx_c;
  logic          rd_en_c;
  logic [AW-1:0] rd_addr_c;
  row_t          rd_data;

  assign wr_en_c   = s_valid && s_ready && (state_q == FILL);
  assign wr_addr_c = AW'(cnt_q);

  // Fetch runs one word ahead of the output register: word k is addressed
  // two cycles before it appears on Weight_o/In_o.
  always_comb begin
    rd_idx_c = '0;
    if (state_q != FILL) begin
      rd_idx_c = (CW+1)'(seq_q) + (CW+1)'(1);
    end
    rd_en_c   = (state_q != WAIT) && (state_q != RESP) && (rd_idx_c < (CW+1)'(DEPTH));
    rd_addr_c = AW'(rd_idx_c);
  end

  matmul_job_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_job_buf (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (s_data),
    .rd_en   (rd_en_c),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = '0;
    tcnt_d  = '0;
    resp_d  = resp_q;
    case (state_q)
      FILL: begin
        if (wr_en_c) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_WR) begin
            state_d = START;
          end
        end
      end
      START: begin
        seq_d   = seq_q + CW'(1);
        state_d = SEND_W;
      end
      SEND_W: begin
        seq_d = seq_q + CW'(1);
        if (seq_q == LAST_W) begin
          state_d = SEND_I;
        end
      end
      SEND_I: begin
        seq_d = seq_q + CW'(1);
        if (seq_q == LAST_I) begin
          seq_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tcnt_d = (tcnt_q == T_LAST) ? tcnt_q : tcnt_q + TW'(1);
        if (VAL_i) begin
          resp_d  = '{data: OUT_i, ov: OV_i, timeout: 1'b0};
          state_d = RESP;
        end else if (tcnt_q == T_LAST) begin
          resp_d  = '{data: '0, ov: 1'b0, timeout: 1'b1};
          state_d = RESP;
        end
      end
      RESP: begin
        if (r_ready) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      seq_q    <= '0;
      tcnt_q   <= '0;
      resp_q   <= '0;
      s_ready  <= 1'b1;
      start_o  <= 1'b0;
      Weight_o <= '0;
      In_o     <= '0;
      r_valid  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      tcnt_q   <= tcnt_d;
      resp_q   <= resp_d;
      s_ready  <= (state_d == FILL);
      start_o  <= (state_d == START);
      Weight_o <= (state_d == SEND_W) ? rd_data : '0;
      In_o     <= (state_d == SEND_I) ? rd_data : '0;
      r_valid  <= (state_d == RESP);
      busy_o   <= !((state_d == FILL) && (cnt_d == '0));
    end
  end

  assign r_data    = resp_q.data;
  assign r_ov      = resp_q.ov;
  assign r_timeout = resp_q.timeout;

endmodule

// File: tb/tb_matmul_feeder.sv
// Randomized self-checking bench for matmul_feeder with a behavioural multiplier.
module tb_matmul_feeder;
  import matmul_pkg::*;

  localparam int N       = 5;
  localparam int T       = 10;
  localparam int TIMEOUT = 64;
  localparam int DEPTH   = N + T;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        s_valid;
  logic        s_ready;
  logic [39:0] s_data;
  logic        start_o;
  logic [39:0] Weight_o;
  logic [39:0] In_o;
  logic [79:0] OUT_i;
  logic        VAL_i;
  logic        OV_i;
  logic        r_valid;
  logic        r_ready;
  logic [79:0] r_data;
  logic        r_ov;
  logic        r_timeout;
  logic        busy_o;

  matmul_feeder #(.N(N), .T(T), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTN(RSTN), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .start_o(start_o), .Weight_o(Weight_o), .In_o(In_o), .OUT_i(OUT_i), .VAL_i(VAL_i),
    .OV_i(OV_i), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_ov(r_ov),
    .r_timeout(r_timeout), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [39:0] job [DEPTH];
  logic [39:0] cap [DEPTH];
  bit          use_override = 1'b0;
  logic [79:0] exp_override = '0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference multiply: result row r = sum over inputs j and lanes l of W[r][l]*X[j][l].
  function automatic logic [79:0] matmul(input bit from_cap);
    logic [79:0] res;
    logic [39:0] wr, xr;
    int          acc;
    res = '0;
    for (int r = 0; r < 5; r++) begin
      acc = 0;
      wr  = from_cap ? cap[r] : job[r];
      for (int j = 0; j < T; j++) begin
        xr = from_cap ? cap[N+j] : job[N+j];
        for (int l = 0; l < 5; l++) begin
          acc += int'(wr[39-8*l -: 8]) * int'(xr[39-8*l -: 8]);
        end
      end
      res[79-16*r -: 16] = acc[15:0];
    end
    return res;
  endfunction

  function automatic logic [79:0] junk80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  task automatic rand_job();
    for (int i = 0; i < DEPTH; i++) job[i] = {$urandom, 8'($urandom)};
  endtask

  task automatic check_reset_vals();
    check_eq("rst_s_ready", 80'(s_ready), 80'(1));
    check_eq("rst_start", 80'(start_o), 80'(0));
    check_eq("rst_weight", 80'(Weight_o), 80'(0));
    check_eq("rst_in", 80'(In_o), 80'(0));
    check_eq("rst_r_valid", 80'(r_valid), 80'(0));
    check_eq("rst_r_data", r_data, 80'(0));
    check_eq("rst_r_ov", 80'(r_ov), 80'(0));
    check_eq("rst_r_timeout", 80'(r_timeout), 80'(0));
    check_eq("rst_busy", 80'(busy_o), 80'(0));
  endtask

  // Offer all job words; leaves the last one driven at the negedge before its handshake.
  task automatic push_job(input bit gap);
    int guard;
    for (int i = 0; i < DEPTH; i++) begin
      if (gap) begin
        @(negedge CLK);
        s_valid = 1'b0;
      end
      @(negedge CLK);
      if (i == 0) check_eq("busy_idle", 80'(busy_o), 80'(0));
      if (i == 1) check_eq("busy_fill", 80'(busy_o), 80'(1));
      if (i == DEPTH-1) check_eq("early_start", 80'(start_o), 80'(0));
      s_valid = 1'b1;
      s_data  = job[i];
      guard   = 0;
      while (!s_ready && guard < 50) begin
        @(negedge CLK);
        guard++;
      end
      if (guard >= 50) check_eq("s_ready_stuck", 80'(s_ready), 80'(1));
    end
  endtask

  // val_at: WAIT cycle index (0 = first WAIT cycle) of the VAL_i pulse, <0 = never.
  task automatic run_job(input bit gap, input int val_at, input bit ov, input bit force_out,
                         input logic [79:0] forced, input int rdy_wait, input int abort_c);
    logic [79:0] exp_data;
    int          wait_c, resp_c;
    bit          tmo;
    push_job(gap);
    tmo    = (val_at < 0) || (val_at > TIMEOUT-1);
    wait_c = 2 + N + T;
    resp_c = tmo ? wait_c + TIMEOUT : wait_c + 1 + val_at;
    for (int c = 1; c <= resp_c; c++) begin
      @(negedge CLK);
      s_valid = 1'($urandom);
      s_data  = {$urandom, 8'($urandom)};
      VAL_i   = 1'b0;
      OV_i    = 1'b0;
      OUT_i   = junk80();
      if (c == 1) begin
        check_eq("start_pulse", 80'(start_o), 80'(1));
        check_eq("s_ready_busy", 80'(s_ready), 80'(0));
      end
      if (c == 2) check_eq("start_once", 80'(start_o), 80'(0));
      if (c >= 2 && c <= 1+N) begin
        cap[c-2] = Weight_o;
        check_eq("weight_row", 80'(Weight_o), 80'(job[c-2]));
        check_eq("in_idle_w", 80'(In_o), 80'(0));
      end
      if (c >= 2+N && c <= 1+N+T) begin
        cap[c-2] = In_o;
        check_eq("input_row", 80'(In_o), 80'(job[c-2]));
        check_eq("weight_idle_i", 80'(Weight_o), 80'(0));
      end
      if (c == wait_c) begin
        check_eq("weight_wait", 80'(Weight_o), 80'(0));
        check_eq("in_wait", 80'(In_o), 80'(0));
      end
      if (c == abort_c) begin
        #1 RSTN = 1'b0;
        #1 check_reset_vals();
        s_valid = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        return;
      end
      if (val_at >= 0 && c == wait_c + val_at) begin
        VAL_i = 1'b1;
        OV_i  = ov;
        OUT_i = force_out ? forced : matmul(1'b1);
      end
      if (c == resp_c - 1) check_eq("r_valid_early", 80'(r_valid), 80'(0));
    end
    exp_data = tmo ? 80'(0) : (force_out ? forced : matmul(1'b0));
    if (use_override) exp_data = exp_override;
    s_valid = 1'b0;
    check_eq("r_valid", 80'(r_valid), 80'(1));
    check_eq("r_data", r_data, exp_data);
    check_eq("r_ov", 80'(r_ov), 80'(tmo ? 1'b0 : ov));
    check_eq("r_timeout", 80'(r_timeout), 80'(tmo));
    for (int k = 0; k < rdy_wait; k++) begin
      @(negedge CLK);
      VAL_i = 1'($urandom);
      OV_i  = 1'($urandom);
      OUT_i = junk80();
      check_eq("hold_valid", 80'(r_valid), 80'(1));
      check_eq("hold_data", r_data, exp_data);
    end
    @(negedge CLK);
    VAL_i   = 1'b0;
    OV_i    = 1'b0;
    r_ready = 1'b1;
    check_eq("pre_hs_data", r_data, exp_data);
    @(negedge CLK);
    r_ready = 1'b0;
    check_eq("post_hs_valid", 80'(r_valid), 80'(0));
    check_eq("post_hs_s_ready", 80'(s_ready), 80'(1));
    check_eq("post_hs_busy", 80'(busy_o), 80'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTN = 1'b0; s_valid = 1'b0; s_data = '0; OUT_i = '0; VAL_i = 1'b0; OV_i = 1'b0;
    r_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_vals();
    RSTN = 1'b1;

    // Unit weights, input row j = {5{j}}: every sum is 5*(0+..+9) = 225.
    for (int i = 0; i < DEPTH; i++) job[i] = (i < N) ? 40'h01_0101_0101 : {5{8'(i - N)}};
    use_override = 1'b1;
    exp_override = 80'h00E1_00E1_00E1_00E1_00E1;
    run_job(1'b0, 1, 1'b0, 1'b0, '0, 0, 0);
    use_override = 1'b0;

    rand_job(); run_job(1'b1, 1, 1'b0, 1'b0, '0, 1, 0);
    rand_job(); run_job(1'b0, -1, 1'b0, 1'b0, '0, 0, 0);
    rand_job(); run_job(1'b0, 1, 1'b1, 1'b1, 80'hFFFF_0001_0002_0003_0004, 5, 0);
    rand_job(); run_job(1'b0, TIMEOUT-1, 1'b1, 1'b0, '0, 1, 0);

    rand_job(); run_job(1'b0, 1, 1'b0, 1'b0, '0, 0, 9);
    rand_job(); run_job(1'b0, 1, 1'b0, 1'b0, '0, 2, 0);

    @(negedge CLK); VAL_i = 1'b1; OV_i = 1'b1; OUT_i = junk80();
    @(negedge CLK); VAL_i = 1'b0; OV_i = 1'b0;
    rand_job(); run_job(1'b0, 1, 1'b0, 1'b0, '0, 0, 0);

    for (int n = 0; n < 8; n++) begin
      rand_job();
      run_job(1'($urandom), int'($urandom_range(0, 70)), 1'($urandom), 1'b0, '0,
              int'($urandom_range(0, 4)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_feeder.md
Name: matmul_feeder

Overview:
- Initiator and driver for the 5x5 systolic matrix-multiply block.
- Accepts N weight rows then T input rows from a host valid/ready stream and buffers the complete job.
- Then issues start and drives the weight and input words on the exact back-to-back cycles the multiplier samples them.
- Waits for the multiplier's result strobe, captures the 80-bit result, and returns it to the host on a valid/ready result port with overflow and timeout flags.

Parameters:
N, 5, number of weight rows per job (each row 5 x 8-bit lanes, 40 bits)
T, 10, number of input rows per job
TIMEOUT, 64, max cycles to wait for VAL_i after the last input word before aborting
DEPTH, N+T, job buffer depth in 40-bit words (derived, not overridable)

Ports:
CLK  input  1  clock, rising edge
RSTN  input  1  asynchronous active-low reset
s_valid  input  1  host job word valid
s_ready  output  1  feeder accepts job word
s_data  input  40  job word: first N weights, then T inputs, lane 0 in [39:32]
start_o  output  1  one-cycle start pulse to multiplier
Weight_o  output  40  weight row to multiplier
In_o  output  40  input row to multiplier
OUT_i  input  80  multiplier result: five 16-bit sums, row 0 in [79:64]
VAL_i  input  1  multiplier result valid (single-cycle)
OV_i  input  1  multiplier overflow flag, qualified by VAL_i
r_valid  output  1  result available to host
r_ready  input  1  host accepts result
r_data  output  80  captured result
r_ov  output  1  captured OV_i
r_timeout  output  1  job aborted, no VAL_i within TIMEOUT
busy_o  output  1  high in any state except FILL with zero words buffered

Behaviour:
- Clock/reset: one clock CLK; reset RSTN asynchronous, active-low. All registers clear on reset.
- Reset values: s_ready=1, start_o=0, Weight_o=0, In_o=0, r_valid=0, r_data=0, r_ov=0, r_timeout=0, busy_o=0; state=FILL; word count=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states and transitions:
  - FILL: s_ready=1. On s_valid&&s_ready, write s_data to buf[cnt] and increment cnt. When cnt reaches DEPTH-1 with a handshake, go to START next cycle.
  - START: start_o=1 for exactly one cycle; s_ready=0; go to SEND_W.
  - SEND_W: N consecutive cycles. Weight_o=buf[k], k=0..N-1, where cycle 1 after start_o holds word 0. Then go to SEND_I.
  - SEND_I: T consecutive cycles. In_o=buf[N+j]. No bubbles are allowed in either send phase. Then go to WAIT.
  - WAIT: Weight_o and In_o return to 0; timeout counter increments each cycle.
    - On VAL_i: latch r_data=OUT_i, r_ov=OV_i, r_timeout=0, then go to RESP.
    - If the counter reaches TIMEOUT-1 without VAL_i: r_data=0, r_ov=0, r_timeout=1, then go to RESP.
  - RESP: r_valid=1, held with r_data/flags stable until r_ready. On handshake: r_valid=0, cnt=0, go to FILL.
- Timing: nominal VAL_i arrives 2 cycles after the last In_o word (compute cycle plus output register). Latency start_o to VAL_i = N+T+2.
- Stray strobes: VAL_i outside WAIT is ignored and does not alter r_data.
- Simultaneous VAL_i and timeout in the same cycle: VAL_i wins and r_timeout=0.
- Host words arriving while s_ready=0 are not consumed; the host must hold them.
- Reset mid-job: immediate return to reset values; the partial buffer is discarded; start_o is never left high.
- Widths: cnt is $clog2(DEPTH+1) bits; the timeout counter is $clog2(TIMEOUT) bits and saturates (no wrap).

Decomposition:
- Shared package matmul_pkg holds:
  - LANE_W=8, LANES=5, ROW_W=40, SUM_W=16, RES_W=80.
  - State enum feeder_state_t {FILL, START, SEND_W, SEND_I, WAIT, RESP}.
- One sub-module: matmul_job_buf, a simple 1W/1R register array of DEPTH x 40 with registered read. Its read address is issued one cycle ahead so Weight_o/In_o stay aligned.

Test Plan:
- Weights all 8'h01, inputs row j = {5{j}}, j=0..9, with a behavioural multiplier model returning VAL_i 2 cycles after the last input → start_o high one cycle; Weight_o=40'h0101010101 on cycles 1..5; In_o row 0 on cycle 6; r_valid with r_data equal to model output; r_ov=0.
- Host s_valid toggling every other cycle during FILL → start_o asserts only after the 15th handshake; send phases are still gap-free (15 consecutive non-idle cycles).
- Multiplier model never asserts VAL_i → r_valid rises at cycle TIMEOUT (64) after entering WAIT, with r_timeout=1 and r_data=0.
- VAL_i with OV_i=1 and OUT_i=80'hFFFF_0001_0002_0003_0004, with r_ready held low 5 cycles → r_valid and r_data stay stable for 5 cycles; r_ov=1; back to FILL after the handshake, s_ready=1.
- RSTN pulsed low during SEND_I (cycle 8 after start) → all outputs at reset values asynchronously. The next full job of 15 words runs correctly from buf[0].
- VAL_i pulsed during FILL, then a normal job → r_data reflects only the in-WAIT result.
